// File: rtl/tcp_tx_arbiter.sv
// Round-robin arbiter that grants per-socket TCP tx control commands to one
// shared packet builder. Each grant ends on downstream ack, socket disable, or timeout.
package tcp_pkg;
  typedef enum logic [2:0] {
    TX_CTRL_NOP  = 3'd0,
    SEND_SYN     = 3'd1,
    SEND_SYN_ACK = 3'd2,
    SEND_ACK     = 3'd3,
    SEND_DATA    = 3'd4,
    SEND_FIN     = 3'd5,
    SEND_RST     = 3'd6
  } tx_ctrl_t;
endpackage

module tcp_tx_arbiter
  import tcp_pkg::*;
#(
  parameter  int NUM_SOCKETS    = 4,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = $clog2(NUM_SOCKETS)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic     [NUM_SOCKETS-1:0]       i_sock_enable,
  input  tx_ctrl_t [NUM_SOCKETS-1:0]       i_req_ctrl,
  input  logic     [NUM_SOCKETS-1:0]       i_req_valid,
  output logic     [NUM_SOCKETS-1:0]       o_req_ack,
  output tx_ctrl_t                         o_tx_ctrl,
  output logic                             o_tx_ctrl_valid,
  output logic     [ID_W-1:0]              o_tx_sock_id,
  input  logic                             i_tx_ctrl_ack,
  output logic                             o_timeout,
  output logic     [ID_W-1:0]              o_timeout_sock_id
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_id;
  tx_ctrl_t         gnt_ctrl;
  logic [CNT_W-1:0] to_cnt;
  logic [ID_W-1:0]  to_id;

  logic [NUM_SOCKETS-1:0] elig;
  logic                   busy;
  logic                   ack_fire;
  logic                   abort;
  logic                   expire;
  logic                   pick_vld;
  logic [ID_W-1:0]        pick_id;
  logic [ID_W-1:0]        gnt_nxt;

  assign busy = (state == BUSY);

  // Per-socket eligibility and one-hot ack decode.
  for (genvar i = 0; i < NUM_SOCKETS; i++) begin : g_lane
    assign elig[i]      = i_req_valid[i] & i_sock_enable[i];
    assign o_req_ack[i] = ack_fire & (gnt_id == ID_W'(i));
  end

  // Ack wins over disable-abort, which wins over timeout.
  assign ack_fire = busy & i_tx_ctrl_ack;
  assign abort    = busy & ~i_tx_ctrl_ack & ~i_sock_enable[gnt_id];
  assign expire   = busy & ~i_tx_ctrl_ack & i_sock_enable[gnt_id] &
                    (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign gnt_nxt = (gnt_id == ID_W'(NUM_SOCKETS - 1)) ? '0 : gnt_id + ID_W'(1);

  // First eligible socket at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 0; k < NUM_SOCKETS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_SOCKETS) j = j - NUM_SOCKETS;
      if (!pick_vld && elig[j]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(j);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_id   <= '0;
      gnt_ctrl <= TX_CTRL_NOP;
      to_cnt   <= '0;
      to_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state    <= BUSY;
            gnt_id   <= pick_id;
            gnt_ctrl <= i_req_ctrl[pick_id];
            to_cnt   <= '0;
          end
        end
        BUSY: begin
          if (ack_fire || abort || expire) begin
            state    <= IDLE;
            gnt_ctrl <= TX_CTRL_NOP;
            rr_ptr   <= gnt_nxt;
            if (expire) to_id <= gnt_id;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // gnt_ctrl is forced to NOP on every exit from BUSY, so it doubles as the idle value.
  assign o_tx_ctrl         = gnt_ctrl;
  assign o_tx_ctrl_valid   = busy;
  assign o_tx_sock_id      = gnt_id;
  assign o_timeout         = expire;
  assign o_timeout_sock_id = to_id;

endmodule
